// File: rtl/ps2_key_encoder_pkg.sv
// Shared types and constants for the PS/2 keyboard front end.
// Holds the frame FSM states, prefix codes and timeout helper.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } frame_state_t;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_REL   = 8'hF0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;

  // Keyboard housekeeping replies, dropped when no prefix is pending
  localparam logic [5:0][7:0] PS2_IGNORE = {
    8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF
  };

  function automatic logic is_ignored(input logic [7:0] code);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 6; i++)
      hit = hit | (code == PS2_IGNORE[i]);
    return hit;
  endfunction

  function automatic int timeout_cyc(input int clk_hz, input int us);
    return clk_hz / 1000000 * us;
  endfunction

endpackage

// File: rtl/ps2_key_encoder_if.sv
// PS/2 pin pair plus decoded event/byte outputs.
// master drives the pins, slave is the encoder.
interface ps2_key_encoder_if;
  logic        ps2_clk;
  logic        ps2_data;
  logic [10:0] ps2_key;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        frame_err;

  modport master (
    output ps2_clk, ps2_data,
    input  ps2_key, rx_byte, rx_valid, frame_err
  );

  modport slave (
    input  ps2_clk, ps2_data,
    output ps2_key, rx_byte, rx_valid, frame_err
  );
endinterface

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: pin sync, clock deglitch, 11-bit frame FSM
// and inter-edge watchdog.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int CLK_HZ     = 48000000,
  parameter int FILTER     = 8,
  parameter int TIMEOUT_US = 2000
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_err
);

  localparam int TO_CYC = timeout_cyc(CLK_HZ, TIMEOUT_US);
  localparam int WDW    = $clog2(TO_CYC + 1);
  localparam int FW     = $clog2(FILTER + 1);

  logic [1:0]    clk_sync;
  logic [1:0]    dat_sync;
  logic          filt;
  logic [FW-1:0] fcnt;
  logic          fall;
  logic          sbit;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      filt     <= 1'b1;
      fcnt     <= '0;
      fall     <= 1'b0;
      sbit     <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
      fall     <= 1'b0;
      if (clk_sync[1] == filt) begin
        fcnt <= '0;
      end else if (fcnt == FW'(FILTER - 1)) begin
        // data is captured together with the filtered edge
        filt <= clk_sync[1];
        fcnt <= '0;
        fall <= filt;
        sbit <= dat_sync[1];
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end
  end

  frame_state_t   state, state_n;
  logic [2:0]     bcnt, bcnt_n;
  logic [7:0]     shreg, sh_n;
  logic           par, par_n;
  logic [WDW-1:0] wd, wd_n;
  logic [7:0]     byte_n;
  logic           vld_n, err_n;

  always_comb begin
    state_n = state;
    bcnt_n  = bcnt;
    sh_n    = shreg;
    par_n   = par;
    wd_n    = wd;
    byte_n  = rx_byte;
    vld_n   = 1'b0;
    err_n   = 1'b0;
    unique case (state)
      ST_IDLE: if (fall && !sbit) begin
        bcnt_n  = '0;
        state_n = ST_DATA;
      end
      ST_DATA: if (fall) begin
        sh_n   = {sbit, shreg[7:1]};
        bcnt_n = bcnt + 3'd1;
        if (bcnt == 3'd7) state_n = ST_PARITY;
      end
      ST_PARITY: if (fall) begin
        par_n   = sbit;
        state_n = ST_STOP;
      end
      ST_STOP: if (fall) begin
        state_n = ST_IDLE;
        if (sbit && (^{shreg, par})) begin
          vld_n  = 1'b1;
          byte_n = shreg;
        end else begin
          err_n = 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    // an edge in the same cycle as expiry wins
    if (state != ST_IDLE) begin
      if (fall) begin
        wd_n = WDW'(1);
      end else if (wd == WDW'(TO_CYC - 1)) begin
        wd_n    = '0;
        err_n   = 1'b1;
        sh_n    = '0;
        state_n = ST_IDLE;
      end else begin
        wd_n = wd + 1'b1;
      end
    end else begin
      wd_n = (fall && !sbit) ? WDW'(1) : '0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state     <= ST_IDLE;
      bcnt      <= '0;
      shreg     <= '0;
      par       <= 1'b0;
      wd        <= '0;
      rx_byte   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      bcnt      <= bcnt_n;
      shreg     <= sh_n;
      par       <= par_n;
      wd        <= wd_n;
      rx_byte   <= byte_n;
      rx_valid  <= vld_n;
      frame_err <= err_n;
    end
  end

endmodule

// File: rtl/ps2_key_encoder.sv
// Native PS/2 keyboard to 11-bit toggle-strobe ps2_key event word.
// Handles E0/F0 prefixes and swallows the E1 Pause sequence.
module ps2_key_encoder
  import ps2_pkg::*;
#(
  parameter int CLK_HZ     = 48000000,
  parameter int FILTER     = 8,
  parameter int TIMEOUT_US = 2000
) (
  input logic clk_sys,
  input logic reset,
  ps2_key_encoder_if.slave bus
);

  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        frame_err;
  logic        ext, rel;
  logic [2:0]  skip;
  logic [10:0] key;

  ps2_frame_rx #(
    .CLK_HZ(CLK_HZ),
    .FILTER(FILTER),
    .TIMEOUT_US(TIMEOUT_US)
  ) u_rx (
    .clk_sys(clk_sys),
    .reset(reset),
    .ps2_clk(bus.ps2_clk),
    .ps2_data(bus.ps2_data),
    .rx_byte(rx_byte),
    .rx_valid(rx_valid),
    .frame_err(frame_err)
  );

  logic skipping, is_ext, is_rel, is_pause;
  logic is_drop, is_emit;

  always_comb begin
    skipping = skip != 3'd0;
    is_ext   = !skipping && rx_byte == PS2_EXT;
    is_rel   = !skipping && rx_byte == PS2_REL;
    is_pause = !skipping && rx_byte == PS2_PAUSE;
    is_drop  = !skipping && !ext && !rel && is_ignored(rx_byte);
    is_emit  = !(skipping || is_ext || is_rel || is_pause || is_drop);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      key  <= '0;
      ext  <= 1'b0;
      rel  <= 1'b0;
      skip <= '0;
    end else if (frame_err) begin
      ext  <= 1'b0;
      rel  <= 1'b0;
      skip <= '0;
    end else if (rx_valid) begin
      unique case (1'b1)
        skipping: begin
          skip <= skip - 3'd1;
          ext  <= 1'b0;
          rel  <= 1'b0;
        end
        is_ext:   ext <= 1'b1;
        is_rel:   rel <= 1'b1;
        is_pause: begin
          skip <= 3'd7;
          ext  <= 1'b0;
          rel  <= 1'b0;
        end
        is_drop: ;
        is_emit: begin
          key <= {~key[10], ~rel, ext, rx_byte};
          ext <= 1'b0;
          rel <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.ps2_key   = key;
  assign bus.rx_byte   = rx_byte;
  assign bus.rx_valid  = rx_valid;
  assign bus.frame_err = frame_err;

endmodule

// File: tb/tb_ps2_key_encoder.sv
// Directed bench for ps2_key_encoder with a scaled clock so that
// PS/2 bit periods and the watchdog fit in a short run.
module tb_ps2_key_encoder;

  localparam int CLK_HZ     = 1000000;
  localparam int FILTER     = 8;
  localparam int TIMEOUT_US = 200;
  localparam int TO         = CLK_HZ / 1000000 * TIMEOUT_US;
  localparam int HALF       = 30;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;

  ps2_key_encoder_if bus();

  ps2_key_encoder #(
    .CLK_HZ(CLK_HZ),
    .FILTER(FILTER),
    .TIMEOUT_US(TIMEOUT_US)
  ) dut (
    .clk_sys(clk_sys),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [7:0]  code;
    bit          flip;
    logic [10:0] key;
    int          dv;
    int          de;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int t_fall = 0;
  int lat_v = -1;
  int lat_e = -1;
  int lat_k = -1;
  int nv = 0;
  int ne = 0;
  logic [10:0] prev_key = '0;

  always @(posedge clk_sys) cyc <= cyc + 1;

  always @(negedge clk_sys) begin
    if (bus.rx_valid === 1'b1) begin
      nv    <= nv + 1;
      lat_v <= cyc - t_fall;
    end
    if (bus.frame_err === 1'b1) begin
      ne    <= ne + 1;
      lat_e <= cyc - t_fall;
    end
    if (bus.ps2_key !== prev_key) begin
      lat_k    <= cyc - t_fall;
      prev_key <= bus.ps2_key;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, got, exp);
    end
  endtask

  task automatic idle(int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic send_bit(bit b, bit glitch);
    @(negedge clk_sys);
    bus.ps2_data = b;
    if (glitch) begin
      idle(10);
      bus.ps2_clk = 1'b0;
      idle(5);
      bus.ps2_clk = 1'b1;
      idle(HALF - 15);
    end else begin
      idle(HALF);
    end
    bus.ps2_clk = 1'b0;
    t_fall = cyc;
    idle(HALF);
    bus.ps2_clk = 1'b1;
  endtask

  task automatic send_frame(logic [7:0] code, bit flip, bit glitch, int nbits);
    logic [10:0] fr;
    fr = {1'b1, (~(^code)) ^ flip, code, 1'b0};
    for (int i = 0; i < nbits; i++)
      send_bit(fr[i], glitch && i == 3);
    bus.ps2_data = 1'b1;
  endtask

  task automatic apply(vec_t v, int idx);
    int v0, e0;
    v0 = nv;
    e0 = ne;
    send_frame(v.code, v.flip, 1'b0, 11);
    idle(10);
    check($sformatf("key[%0d]", idx), 32'(bus.ps2_key), 32'(v.key));
    check($sformatf("nvalid[%0d]", idx), nv - v0, v.dv);
    check($sformatf("nerr[%0d]", idx), ne - e0, v.de);
    if (v.dv == 1)
      check($sformatf("byte[%0d]", idx), 32'(bus.rx_byte), 32'(v.code));
  endtask

  vec_t tv1[9];
  vec_t tv2[16];
  int v0, e0;

  initial begin
    tv1[0] = '{8'h29, 1'b0, 11'h629, 1, 0};
    tv1[1] = '{8'hF0, 1'b0, 11'h629, 1, 0};
    tv1[2] = '{8'h29, 1'b0, 11'h029, 1, 0};
    tv1[3] = '{8'hE0, 1'b0, 11'h029, 1, 0};
    tv1[4] = '{8'hF0, 1'b0, 11'h029, 1, 0};
    tv1[5] = '{8'h6B, 1'b0, 11'h56B, 1, 0};
    tv1[6] = '{8'h74, 1'b0, 11'h274, 1, 0};
    tv1[7] = '{8'h1C, 1'b1, 11'h274, 0, 1};
    tv1[8] = '{8'h1C, 1'b0, 11'h61C, 1, 0};

    tv2[0]  = '{8'h74, 1'b0, 11'h274, 1, 0};
    tv2[1]  = '{8'hAA, 1'b0, 11'h274, 1, 0};
    tv2[2]  = '{8'hE1, 1'b0, 11'h274, 1, 0};
    tv2[3]  = '{8'h14, 1'b0, 11'h274, 1, 0};
    tv2[4]  = '{8'h77, 1'b0, 11'h274, 1, 0};
    tv2[5]  = '{8'hE1, 1'b0, 11'h274, 1, 0};
    tv2[6]  = '{8'hF0, 1'b0, 11'h274, 1, 0};
    tv2[7]  = '{8'h14, 1'b0, 11'h274, 1, 0};
    tv2[8]  = '{8'hF0, 1'b0, 11'h274, 1, 0};
    tv2[9]  = '{8'h77, 1'b0, 11'h274, 1, 0};
    tv2[10] = '{8'h29, 1'b0, 11'h629, 1, 0};
    tv2[11] = '{8'hE0, 1'b0, 11'h629, 1, 0};
    tv2[12] = '{8'hAA, 1'b0, 11'h3AA, 1, 0};
    tv2[13] = '{8'hE0, 1'b0, 11'h3AA, 1, 0};
    tv2[14] = '{8'h55, 1'b1, 11'h3AA, 0, 1};
    tv2[15] = '{8'h6B, 1'b0, 11'h66B, 1, 0};

    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    reset = 1'b1;
    idle(5);
    check("rst_key", 32'(bus.ps2_key), 32'h0);
    check("rst_byte", 32'(bus.rx_byte), 32'h0);
    check("rst_valid", 32'(bus.rx_valid), 32'h0);
    check("rst_err", 32'(bus.frame_err), 32'h0);
    reset = 1'b0;
    idle(5);

    for (int i = 0; i < 9; i++) apply(tv1[i], i);
    check("lat_valid", lat_v, FILTER + 3);
    check("lat_key", lat_k, FILTER + 4);

    // partial frame: start + 4 data bits, then clock stays high
    v0 = nv;
    e0 = ne;
    send_frame(8'h74, 1'b0, 1'b0, 5);
    idle(TO + 50);
    check("to_nerr", ne - e0, 1);
    check("to_nvalid", nv - v0, 0);
    check("to_lat", lat_e, FILTER + 2 + TO);
    check("to_key", 32'(bus.ps2_key), 32'h61C);

    for (int i = 0; i < 16; i++) apply(tv2[i], 100 + i);

    v0 = nv;
    e0 = ne;
    send_frame(8'h1C, 1'b0, 1'b1, 11);
    idle(10);
    check("gl_key", 32'(bus.ps2_key), 32'h21C);
    check("gl_nvalid", nv - v0, 1);
    check("gl_nerr", ne - e0, 0);

    send_frame(8'h29, 1'b0, 1'b0, 6);
    idle(5);
    reset = 1'b1;
    idle(3);
    reset = 1'b0;
    idle(2);
    check("mid_rst_key", 32'(bus.ps2_key), 32'h0);
    check("mid_rst_byte", 32'(bus.rx_byte), 32'h0);
    v0 = nv;
    send_frame(8'h29, 1'b0, 1'b0, 11);
    idle(10);
    check("post_rst_key", 32'(bus.ps2_key), 32'h629);
    check("post_rst_nvalid", nv - v0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
